// File: rtl/mult_div_unit.sv
// Iterative integer multiply/divide unit: shift-add multiply and restoring divide, one bit per clock.
// Optional feature macro DIV_EN builds the divider; without it divide ops complete at once with no effect.
`ifndef MAX_LENGTH
`define MAX_LENGTH 32
`endif

module mult_div_unit #(
   parameter int WIDTH = `MAX_LENGTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_FIXUP = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic               sign_a_q, sign_a_d;
   logic               sign_b_q, sign_b_d;
   logic               done_q, done_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;

   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_step;
   logic [2*WIDTH-1:0] prod_fix;

   // Magnitudes of the incoming operands; op[0] selects signed interpretation.
   always_comb begin
      mag_a = (op[0] && operand_a[WIDTH-1]) ? -operand_a : operand_a;
      mag_b = (op[0] && operand_b[WIDTH-1]) ? -operand_b : operand_b;
   end

   // Multiply: acc holds {partial product, remaining multiplier bits}; opnd is the multiplicand.
   always_comb begin
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      mul_step = {mul_sum, acc_q[WIDTH-1:1]};
      prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
   end

`ifdef DIV_EN
   logic               is_div_q, is_div_d;
   logic               dbz_q, dbz_d;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH-1:0]   div_diff;
   logic               div_fits;
   logic [2*WIDTH-1:0] div_step;
   logic [WIDTH-1:0]   rem_mag, quo_mag;
   logic [WIDTH-1:0]   rem_fix, quo_fix;
   logic               div_zero;

   // Divide: acc holds {partial remainder, dividend bits shifting out / quotient bits shifting in}.
   always_comb begin
      div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_fits  = (div_shift >= {1'b0, opnd_q});
      div_diff  = div_shift[WIDTH-1:0] - opnd_q;
      div_step  = {(div_fits ? div_diff : div_shift[WIDTH-1:0]), acc_q[WIDTH-2:0], div_fits};
      rem_mag   = acc_q[2*WIDTH-1:WIDTH];
      quo_mag   = acc_q[WIDTH-1:0];
      rem_fix   = sign_a_q ? -rem_mag : rem_mag;
      quo_fix   = (sign_a_q ^ sign_b_q) ? -quo_mag : quo_mag;
      div_zero  = (opnd_q == '0);
   end
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      opnd_d   = opnd_q;
      sign_a_d = sign_a_q;
      sign_b_d = sign_b_q;
      done_d   = 1'b0;
      hi_d     = hi_q;
      lo_d     = lo_q;
`ifdef DIV_EN
      is_div_d = is_div_q;
      dbz_d    = dbz_q;
`endif
      case (state_q)
         S_IDLE: begin
`ifdef DIV_EN
            if (start) begin
`else
            if (start && !op[1]) begin
`endif
               state_d  = S_RUN;
               cnt_d    = '0;
               sign_a_d = op[0] & operand_a[WIDTH-1];
               sign_b_d = op[0] & operand_b[WIDTH-1];
`ifdef DIV_EN
               is_div_d = op[1];
               dbz_d    = 1'b0;
               if (op[1]) begin
                  acc_d  = {{WIDTH{1'b0}}, mag_a};
                  opnd_d = mag_b;
               end else begin
                  acc_d  = {{WIDTH{1'b0}}, mag_b};
                  opnd_d = mag_a;
               end
`else
               acc_d  = {{WIDTH{1'b0}}, mag_b};
               opnd_d = mag_a;
`endif
            end
`ifndef DIV_EN
            // Divide requested but not built: acknowledge immediately, results untouched.
            if (start && op[1]) begin
               done_d = 1'b1;
            end
`endif
         end
         S_RUN: begin
            cnt_d = cnt_q + CW'(1);
`ifdef DIV_EN
            acc_d = is_div_q ? div_step : mul_step;
`else
            acc_d = mul_step;
`endif
            if (cnt_q == CW'(WIDTH-1)) begin
               state_d = S_FIXUP;
            end
         end
         S_FIXUP: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
`ifdef DIV_EN
            if (is_div_q) begin
               // With a zero divisor the remainder path already reproduces operand_a.
               hi_d  = rem_fix;
               lo_d  = div_zero ? '1 : quo_fix;
               dbz_d = div_zero;
            end else
`endif
            begin
               hi_d = prod_fix[2*WIDTH-1:WIDTH];
               lo_d = prod_fix[WIDTH-1:0];
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         opnd_q   <= '0;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         done_q   <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
`ifdef DIV_EN
         is_div_q <= 1'b0;
         dbz_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         opnd_q   <= opnd_d;
         sign_a_q <= sign_a_d;
         sign_b_q <= sign_b_d;
         done_q   <= done_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
`ifdef DIV_EN
         is_div_q <= is_div_d;
         dbz_q    <= dbz_d;
`endif
      end
   end

   assign busy = (state_q != S_IDLE);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;
`ifdef DIV_EN
   assign div_by_zero = dbz_q;
`else
   assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and random checks of mult_div_unit against a plain-arithmetic reference model.
module tb_mult_div_unit;

   localparam int W = 32;
`ifdef DIV_EN
   localparam bit DIV_BUILT = 1'b1;
`else
   localparam bit DIV_BUILT = 1'b0;
`endif

   logic         clk;
   logic         reset;
   logic         start;
   logic [1:0]   op;
   logic [W-1:0] operand_a;
   logic [W-1:0] operand_b;
   logic         busy;
   logic         done;
   logic         div_by_zero;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   int n_checks = 0;
   int n_fail   = 0;

   logic [W-1:0] exp_hi;
   logic [W-1:0] exp_lo;
   logic         exp_dbz;

   mult_div_unit dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .op          (op),
      .operand_a   (operand_a),
      .operand_b   (operand_b),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .hi          (hi),
      .lo          (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Reference result from the arithmetic definition of each op.
   function automatic void model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [63:0] p;
      logic [63:0] qv;
      logic [63:0] rv;
      longint sa;
      longint sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      exp_dbz = 1'b0;
      case (o)
         2'd0: begin
            p = {32'd0, a} * {32'd0, b};
            {exp_hi, exp_lo} = p;
         end
         2'd1: begin
            p = sa * sb;
            {exp_hi, exp_lo} = p;
         end
         default: begin
            if (DIV_BUILT) begin
               if (b == 0) begin
                  exp_hi  = a;
                  exp_lo  = '1;
                  exp_dbz = 1'b1;
               end else if (o == 2'd2) begin
                  exp_lo = a / b;
                  exp_hi = a % b;
               end else begin
                  qv = sa / sb;
                  rv = sa % sb;
                  exp_lo = qv[31:0];
                  exp_hi = rv[31:0];
               end
            end
         end
      endcase
   endfunction

   function automatic int lat(input logic [1:0] o);
      return (o[1] && !DIV_BUILT) ? 0 : W + 1;
   endfunction

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic launch(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      start     = 1'b1;
      op        = o;
      operand_a = a;
      operand_b = b;
      model(o, a, b);
      @(posedge clk);
      @(negedge clk);
      start     = 1'b0;
      op        = 2'($urandom_range(0, 3));
      operand_a = $urandom;
      operand_b = $urandom;
   endtask

   // Counts remaining busy cycles, then checks the result in the done cycle.
   task automatic finish_op(input string tag, input int exp_busy);
      int busy_cycles;
      int done_in_busy;
      int guard;
      busy_cycles  = 0;
      done_in_busy = 0;
      guard        = 0;
      while (busy === 1'b1 && guard < 200) begin
         if (done === 1'b1) done_in_busy++;
         busy_cycles++;
         guard++;
         @(negedge clk);
      end
      check({tag, "_busy_cycles"}, busy_cycles, exp_busy);
      check({tag, "_done_in_busy"}, done_in_busy, 0);
      check({tag, "_done"}, done, 1'b1);
      check({tag, "_hi"}, hi, exp_hi);
      check({tag, "_lo"}, lo, exp_lo);
      check({tag, "_dbz"}, div_by_zero, exp_dbz);
   endtask

   initial begin
      int done_seen;
      logic [1:0]   r_op;
      logic [W-1:0] r_a;
      logic [W-1:0] r_b;

      reset     = 1'b1;
      start     = 1'b0;
      op        = 2'd0;
      operand_a = '0;
      operand_b = '0;
      exp_hi    = '0;
      exp_lo    = '0;
      exp_dbz   = 1'b0;

      repeat (3) @(negedge clk);
      check("reset_busy", busy, 1'b0);
      check("reset_done", done, 1'b0);
      check("reset_dbz", div_by_zero, 1'b0);
      check("reset_hi", hi, '0);
      check("reset_lo", lo, '0);
      reset = 1'b0;
      @(negedge clk);

      launch(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      finish_op("multu_max", lat(2'd0));
      check("multu_max_hi_const", hi, 32'hFFFF_FFFE);
      check("multu_max_lo_const", lo, 32'h0000_0001);
      @(negedge clk);
      check("done_one_cycle", done, 1'b0);
      check("idle_after_done", busy, 1'b0);

      launch(2'd1, 32'hFFFF_FFFD, 32'd7);
      finish_op("mult_neg", lat(2'd1));
      check("mult_neg_hi_const", hi, 32'hFFFF_FFFF);
      check("mult_neg_lo_const", lo, 32'hFFFF_FFEB);
      @(negedge clk);

      launch(2'd3, 32'hFFFF_FFF9, 32'd2);
      finish_op("div_neg", lat(2'd3));
`ifdef DIV_EN
      check("div_neg_lo_const", lo, 32'hFFFF_FFFD);
      check("div_neg_hi_const", hi, 32'hFFFF_FFFF);
`endif
      launch(2'd2, 32'd100, 32'd7);
      finish_op("divu_100_7", lat(2'd2));
`ifdef DIV_EN
      check("divu_100_7_lo_const", lo, 32'd14);
      check("divu_100_7_hi_const", hi, 32'd2);
`endif
      launch(2'd3, 32'h8000_0000, 32'hFFFF_FFFF);
      finish_op("div_overflow", lat(2'd3));

      launch(2'd2, 32'd5, 32'd0);
      finish_op("divu_zero", lat(2'd2));
      @(negedge clk);
      check("dbz_holds_after_done", div_by_zero, exp_dbz);
      launch(2'd0, 32'd2, 32'd3);
      check("dbz_cleared_on_start", div_by_zero, 1'b0);
      finish_op("multu_after_dz", lat(2'd0));
      repeat (2) @(negedge clk);

      // A second start in cycle 5 of a multiply must be ignored.
      launch(2'd0, 32'h1234_5678, 32'h9ABC_DEF0);
      repeat (4) @(negedge clk);
      start     = 1'b1;
      op        = 2'd1;
      operand_a = 32'd7;
      operand_b = 32'd9;
      @(negedge clk);
      start = 1'b0;
      finish_op("ignore_start", lat(2'd0) - 5);
      @(negedge clk);

      // Back-to-back: next start issued in the done cycle.
      launch(2'd0, 32'd3, 32'd4);
      finish_op("b2b_first", lat(2'd0));
      check("b2b_first_lo_const", lo, 32'd12);
      launch(2'd0, 32'd5, 32'd6);
      finish_op("b2b_second", lat(2'd0));
      check("b2b_second_lo_const", lo, 32'd30);
      @(negedge clk);

      // Reset during RUN aborts the operation.
      launch(2'd1, 32'hDEAD_BEEF, 32'h0BAD_F00D);
      repeat (8) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset   = 1'b0;
      exp_hi  = '0;
      exp_lo  = '0;
      exp_dbz = 1'b0;
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      check("abort_hi", hi, '0);
      check("abort_lo", lo, '0);
      done_seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) done_seen++;
      end
      check("abort_no_done_pulse", done_seen, 0);

      for (int i = 0; i < 24; i++) begin
         r_op = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 7))
            0:       r_b = '0;
            1:       r_b = $urandom_range(1, 9);
            2:       r_b = 32'hFFFF_FFFF;
            default: r_b = $urandom;
         endcase
         r_a = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
         launch(r_op, r_a, r_b);
         finish_op($sformatf("rand%0d_op%0d", i, r_op), lat(r_op));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
